// File: rtl/tt_edge_loader.sv
// Edge-list front end for the BFS core: takes a query plus its edges, removes self-loops
// and duplicates, replays the cleaned list as one in_valid burst and reports the core's result.
module tt_edge_loader #(
  parameter int unsigned DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       s_last,
  input  logic [3:0] s_a,
  input  logic [3:0] s_b,
  output logic       tt_in_valid,
  output logic [3:0] tt_source,
  output logic [3:0] tt_destination,
  input  logic       tt_out_valid,
  input  logic [3:0] tt_cost,
  output logic       res_valid,
  output logic [3:0] res_cost,
  output logic [5:0] res_edges,
  output logic [5:0] res_drop,
  output logic       res_ovf
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [5:0]  EMAX = 6'(DEPTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_REPLAY = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]   state, state_nx;
  logic [7:0]   mem [DEPTH];
  logic [119:0] seen;
  logic [5:0]   rp;
  logic         xfer, is_loop, is_dup, has_space, store, query_trivial;
  logic [3:0]   lo, hi;
  logic [7:0]   prod;
  logic [6:0]   pidx;

  always_comb begin
    xfer          = s_valid && s_ready;
    is_loop       = (s_a == s_b);
    lo            = (s_a < s_b) ? s_a : s_b;
    hi            = (s_a < s_b) ? s_b : s_a;
    // Strict upper triangle (lo < hi): row hi starts at hi*(hi-1)/2, 120 cells total
    prod          = {4'b0, hi} * ({4'b0, hi} - 8'd1);
    pidx          = 7'(prod >> 1) + {3'b0, lo};
    is_dup        = seen[pidx];
    has_space     = (res_edges < EMAX);
    store         = xfer && (state == S_LOAD) && !is_loop && !is_dup && has_space;
    query_trivial = (mem[0][7:4] == mem[0][3:0]);

    state_nx = state;
    case (state)
      S_IDLE:   if (xfer) state_nx = !s_last ? S_LOAD : (is_loop ? S_DONE : S_REPLAY);
      S_LOAD:   if (xfer && s_last) state_nx = query_trivial ? S_DONE : S_REPLAY;
      S_REPLAY: if (rp > res_edges) state_nx = S_WAIT;
      S_WAIT:   if (tt_out_valid) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Entry 0 holds the query; edges fill entries 1..DEPTH-1 in arrival order
  always_ff @(posedge clk) begin
    if (xfer && state == S_IDLE) mem[0] <= {s_a, s_b};
    else if (store)              mem[AW'(res_edges + 6'd1)] <= {s_a, s_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      s_ready        <= 1'b0;
      seen           <= '0;
      rp             <= '0;
      tt_in_valid    <= 1'b0;
      tt_source      <= '0;
      tt_destination <= '0;
      res_valid      <= 1'b0;
      res_cost       <= '0;
      res_edges      <= '0;
      res_drop       <= '0;
      res_ovf        <= 1'b0;
    end else begin
      state     <= state_nx;
      s_ready   <= (state_nx == S_IDLE) || (state_nx == S_LOAD);
      res_valid <= (state_nx == S_DONE);
      case (state)
        S_IDLE: if (xfer) begin
          seen      <= '0;
          rp        <= '0;
          res_cost  <= '0;
          res_edges <= '0;
          res_drop  <= '0;
          res_ovf   <= 1'b0;
        end
        S_LOAD: if (xfer) begin
          if (is_loop || is_dup) begin
            if (res_drop != 6'd63) res_drop <= res_drop + 6'd1;
          end else if (has_space) begin
            seen[pidx] <= 1'b1;
            res_edges  <= res_edges + 6'd1;
          end else begin
            res_ovf <= 1'b1;
          end
        end
        S_REPLAY: begin
          if (rp <= res_edges) begin
            tt_in_valid                 <= 1'b1;
            {tt_source, tt_destination} <= mem[AW'(rp)];
            rp                          <= rp + 6'd1;
          end else begin
            tt_in_valid    <= 1'b0;
            tt_source      <= '0;
            tt_destination <= '0;
          end
        end
        S_WAIT: if (tt_out_valid) res_cost <= tt_cost;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_edge_loader.sv
// Scoreboard bench for tt_edge_loader: a 32-deep and a 4-deep instance, a responding core
// model, and directed transactions with hand-computed bursts and results.
module tb_tt_edge_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0, s_last = 1'b0, sel = 1'b0;
  logic [3:0] s_a = '0, s_b = '0;
  logic       tt_out_valid = 1'b0;
  logic [3:0] tt_cost = '0;

  logic       s_ready_a, tt_in_valid_a, res_valid_a, res_ovf_a;
  logic [3:0] tt_source_a, tt_destination_a, res_cost_a;
  logic [5:0] res_edges_a, res_drop_a;
  logic       s_ready_b, tt_in_valid_b, res_valid_b, res_ovf_b;
  logic [3:0] tt_source_b, tt_destination_b, res_cost_b;
  logic [5:0] res_edges_b, res_drop_b;

  always #5 clk = ~clk;

  tt_edge_loader #(.DEPTH(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid && !sel), .s_ready(s_ready_a), .s_last(s_last),
    .s_a(s_a), .s_b(s_b), .tt_in_valid(tt_in_valid_a), .tt_source(tt_source_a),
    .tt_destination(tt_destination_a), .tt_out_valid(tt_out_valid), .tt_cost(tt_cost),
    .res_valid(res_valid_a), .res_cost(res_cost_a), .res_edges(res_edges_a),
    .res_drop(res_drop_a), .res_ovf(res_ovf_a)
  );

  tt_edge_loader #(.DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid && sel), .s_ready(s_ready_b), .s_last(s_last),
    .s_a(s_a), .s_b(s_b), .tt_in_valid(tt_in_valid_b), .tt_source(tt_source_b),
    .tt_destination(tt_destination_b), .tt_out_valid(tt_out_valid), .tt_cost(tt_cost),
    .res_valid(res_valid_b), .res_cost(res_cost_b), .res_edges(res_edges_b),
    .res_drop(res_drop_b), .res_ovf(res_ovf_b)
  );

  logic       m_ready, m_in_valid, m_res_valid, m_ovf;
  logic [3:0] m_src, m_dst, m_cost;
  logic [5:0] m_edges, m_drop;
  assign m_ready     = sel ? s_ready_b        : s_ready_a;
  assign m_in_valid  = sel ? tt_in_valid_b    : tt_in_valid_a;
  assign m_src       = sel ? tt_source_b      : tt_source_a;
  assign m_dst       = sel ? tt_destination_b : tt_destination_a;
  assign m_res_valid = sel ? res_valid_b      : res_valid_a;
  assign m_cost      = sel ? res_cost_b       : res_cost_a;
  assign m_edges     = sel ? res_edges_b      : res_edges_a;
  assign m_drop      = sel ? res_drop_b       : res_drop_a;
  assign m_ovf       = sel ? res_ovf_b        : res_ovf_a;

  int applied = 0, miscompares = 0, res_seen = 0;
  logic [7:0]  exp_beat[$];
  int          exp_len[$];
  logic [3:0]  exp_cost[$];
  logic [16:0] exp_res[$];

  task automatic check(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input int act);
    applied++;
    miscompares++;
    $display("FAIL %s: got %0d, nothing expected", name, act);
  endtask

  task automatic expect_beat(input logic [3:0] a, input logic [3:0] b);
    exp_beat.push_back({a, b});
  endtask

  task automatic expect_burst(input int len, input logic [3:0] cost);
    exp_len.push_back(len);
    exp_cost.push_back(cost);
  endtask

  task automatic expect_res(input logic [3:0] c, input logic [5:0] e, input logic [5:0] d, input logic o);
    exp_res.push_back({c, e, d, o});
  endtask

  // Monitor plus core model: checks beats, burst lengths and results; answers each burst
  int         run = 0, dly = 0;
  logic       pend = 1'b0;
  logic [3:0] pcost = '0;
  logic [16:0] r;
  always @(negedge clk) begin
    tt_out_valid = 1'b0;
    if (!rst_n) begin
      run  = 0;
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (dly == 0) begin
          tt_out_valid = 1'b1;
          tt_cost      = pcost;
          pend         = 1'b0;
        end else dly--;
      end
      if (m_in_valid) begin
        if (exp_beat.size() == 0) unexpected("beat", {m_src, m_dst});
        else check("beat", {m_src, m_dst}, exp_beat.pop_front());
        run++;
      end else if (run > 0) begin
        if (exp_len.size() == 0) unexpected("burst_len", run);
        else begin
          check("burst_len", run, exp_len.pop_front());
          pcost = exp_cost.pop_front();
          pend  = 1'b1;
          dly   = 2;
        end
        run = 0;
      end
      if (m_res_valid) begin
        res_seen++;
        if (exp_res.size() == 0) unexpected("res_valid", 1);
        else begin
          r = exp_res.pop_front();
          check("res_cost", m_cost, r[16:13]);
          check("res_edges", m_edges, r[12:7]);
          check("res_drop", m_drop, r[6:1]);
          check("res_ovf", m_ovf, r[0]);
        end
      end
    end
  end

  task automatic beat(input logic [3:0] a, input logic [3:0] b, input logic last, input int bub);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1; s_a = a; s_b = b; s_last = last;
    while (!m_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("s_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
    repeat (bub) @(negedge clk);
  endtask

  task automatic wait_res();
    int start = res_seen;
    int n = 0;
    while (res_seen == start && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("res_arrived", int'(res_seen != start), 1);
  endtask

  task automatic scen1(input int bub);
    expect_beat(0, 3); expect_beat(0, 1); expect_beat(1, 2); expect_beat(2, 3);
    expect_burst(4, 3);
    expect_res(3, 3, 0, 0);
    beat(0, 3, 0, bub); beat(0, 1, 0, bub); beat(1, 2, 0, bub); beat(2, 3, 1, 0);
    wait_res();
  endtask

  initial begin
    #12;
    check("rst_s_ready", s_ready_a, 0);
    check("rst_in_valid", tt_in_valid_a, 0);
    check("rst_res_valid", res_valid_a, 0);
    check("rst_outputs_b", {s_ready_b, tt_in_valid_b, res_valid_b, res_cost_b, res_edges_b, res_drop_b, res_ovf_b}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("s_ready_after_rst", s_ready_a, 1);
    check("s_ready_after_rst_b", s_ready_b, 1);

    scen1(0);
    @(negedge clk);
    check("hold_res_valid", res_valid_a, 0);
    check("hold_res_cost", res_cost_a, 3);
    check("hold_res_edges", res_edges_a, 3);

    // Duplicates in both orientations plus a self-loop
    expect_beat(1, 6); expect_beat(1, 2); expect_beat(2, 6);
    expect_burst(3, 5);
    expect_res(5, 2, 3, 0);
    beat(1, 6, 0, 0); beat(1, 2, 0, 0); beat(2, 1, 0, 0); beat(1, 2, 0, 0);
    beat(4, 4, 0, 0); beat(2, 6, 1, 0);
    wait_res();

    // Trivial query: no burst
    expect_res(0, 1, 0, 0);
    beat(5, 5, 0, 0); beat(5, 7, 1, 0);
    wait_res();

    // Single-beat query, core reports unreachable
    expect_beat(2, 8);
    expect_burst(1, 0);
    expect_res(0, 0, 0, 0);
    beat(2, 8, 1, 0);
    wait_res();

    // Drop counter saturation
    expect_beat(1, 2); expect_beat(3, 4);
    expect_burst(2, 9);
    expect_res(9, 1, 63, 0);
    beat(1, 2, 0, 0); beat(3, 4, 0, 0);
    for (int k = 0; k < 70; k++) beat(4'(k % 16), 4'(k % 16), 0, 0);
    beat(5, 5, 1, 0);
    wait_res();

    // Overflow on the 4-deep instance; repeated overflowed edge is not a drop
    sel = 1'b1;
    expect_beat(0, 9); expect_beat(0, 1); expect_beat(1, 2); expect_beat(2, 3);
    expect_burst(4, 7);
    expect_res(7, 3, 0, 1);
    beat(0, 9, 0, 0); beat(0, 1, 0, 0); beat(1, 2, 0, 0); beat(2, 3, 0, 0);
    beat(3, 9, 0, 0); beat(0, 9, 0, 0); beat(3, 9, 1, 0);
    wait_res();
    sel = 1'b0;

    scen1(2);

    // Reset during the burst
    expect_beat(0, 3);
    beat(0, 3, 0, 0); beat(0, 1, 1, 0);
    begin
      int n = 0;
      while (!tt_in_valid_a && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("burst_started", tt_in_valid_a, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_in_valid", tt_in_valid_a, 0);
    check("mid_rst_s_ready", s_ready_a, 0);
    check("mid_rst_edges", res_edges_a, 0);
    exp_beat.delete(); exp_len.delete(); exp_cost.delete(); exp_res.delete();
    repeat (3) @(negedge clk);
    check("no_res_in_rst", res_valid_a, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("s_ready_after_rst2", s_ready_a, 1);
    scen1(0);

    repeat (5) @(negedge clk);
    check("beats_left", exp_beat.size(), 0);
    check("bursts_left", exp_len.size(), 0);
    check("results_left", exp_res.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tt_edge_loader.md
Name: tt_edge_loader

Overview:
- Upstream front end for the shortest-path (BFS) core. Accepts one query plus its edge list over a valid/ready stream, which may contain bubbles.
- Discards self-loops and duplicate edges, then buffers the cleaned list.
- Replays the list to the core as one contiguous in_valid burst, with the query pair on the first beat and edges after it.
- Waits for the core's out_valid/cost and returns a one-cycle result with statistics.

Parameters:
- DEPTH, 32, buffer entries, including the query entry; legal range 2..63.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  upstream beat valid
- s_ready  out  1  block can accept a beat
- s_last  in  1  final beat of transaction
- s_a  in  4  first beat: query source; later beats: edge endpoint A
- s_b  in  4  first beat: query destination; later beats: edge endpoint B
- tt_in_valid  out  1  to core in_valid
- tt_source  out  4  to core source
- tt_destination  out  4  to core destination
- tt_out_valid  in  1  from core out_valid
- tt_cost  in  4  from core cost
- res_valid  out  1  result strobe, one cycle
- res_cost  out  4  path cost; 0 = unreachable or trivial query
- res_edges  out  6  edges forwarded to core
- res_drop  out  6  edges discarded as self-loop/duplicate, saturates at 63
- res_ovf  out  1  one or more distinct edges lost to full buffer

Behaviour:
- Reset: all outputs 0, except s_ready.
  - s_ready = 0 during reset; becomes 1 in IDLE on the first clock edge after release.
  - Dedup bitmap, counters, write/read pointers and state are cleared.
- States: IDLE, LOAD, REPLAY, WAIT, DONE.
- Beat transfer occurs on s_valid && s_ready at a rising edge.
- s_ready = 1 only in IDLE and LOAD; 0 in all other states.
- IDLE:
  - Transferred beat = query; stored at entry 0 unconditionally.
  - Clear bitmap and counters.
  - s_last on this beat means zero edges; otherwise go to LOAD.
- LOAD: each transferred beat is one edge.
  - Self-loop (s_a == s_b): drop; res_drop++.
  - Pair already seen in either orientation (symmetric 16x16 bitmap, only the upper triangle stored): drop; res_drop++.
  - Else if buffer has space: store, set bitmap, res_edges++.
  - Else: discard and set res_ovf. Do not set bitmap, so a repeat of an overflowed edge also counts as overflow, not as a drop.
  - s_valid low cycles are bubbles: no state change.
- After the s_last beat transfers:
  - If query source == destination: go to DONE with res_cost = 0. The core is never driven.
  - Otherwise go to REPLAY on the next cycle.
- REPLAY:
  - Registered outputs: tt_in_valid = 1 with entry k on cycle k, for k = 0..res_edges, with no gaps.
  - The burst length is therefore res_edges + 1 cycles, and entry 0 (the query) is always first.
  - On the cycle after the final entry: tt_in_valid = 0, tt_source/tt_destination = 0, state = WAIT.
- WAIT:
  - Hold until tt_out_valid == 1; capture tt_cost into res_cost; go to DONE.
  - There is no timeout; the core always answers.
  - tt_out_valid outside WAIT is ignored.
- DONE: res_valid = 1 for exactly one cycle, together with res_cost/res_edges/res_drop/res_ovf; next state IDLE.
- Result fields hold their values after res_valid drops, until the next query beat is accepted.
- Back-to-back transactions: a new query is accepted in IDLE the cycle after DONE. Minimum gap between queries is therefore LOAD + REPLAY + WAIT + 2 cycles.
- Width rules: res_edges ≤ DEPTH-1 ≤ 62; res_drop saturates at 63, never wraps.
- Reset mid-operation: everything returns immediately to reset values, including tt_in_valid = 0. A partial burst is abandoned with no result; the core shares rst_n.
- Single-beat transaction (s_valid and s_last on the first beat) with distinct endpoints: burst of 1 cycle. Core reports cost 0 if unreachable and the result is passed through.

Test Plan:
- Query (0,3), edges (0,1),(1,2),(2,3), last → tt_in_valid for 4 contiguous cycles carrying (0,3),(0,1),(1,2),(2,3); bench core returns 3 → res_valid 1 cycle with cost=3, edges=3, drop=0, ovf=0.
- Query (1,6), edges (1,2),(2,1),(1,2),(4,4),(2,6) → burst carries (1,6),(1,2),(2,6); res_edges=2, res_drop=3.
- Query (5,5), edges (5,7) → tt_in_valid never asserts; res_valid 1 cycle after the last transfer, cost=0, edges=1.
- DEPTH=4: query (0,9), distinct edges (0,1),(1,2),(2,3),(3,9),(0,9) → burst carries the query plus the first 3 edges only; res_ovf=1, res_edges=3.
- Same transaction as scenario 1 with 2-cycle s_valid bubbles between beats → identical gap-free 4-cycle burst and identical result.
- Assert rst_n low in the 2nd REPLAY cycle → tt_in_valid drops asynchronously, no res_valid; a new transaction after release completes normally.
